sprite_rom_arbiter: RTL
=======================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one synchronous sprite ROM read port (address in, palette index out) between
//  NUM_REQ pixel requesters, e.g. background, player and enemy sprite renderers.
//  Grants one request per cycle with round-robin priority and drives the ROM address.
//  Tracks in-flight reads and returns each ROM word tagged with its requester ID.
//  Sits between the per-sprite draw logic and the shared ROM/palette pair.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  ADDR_W       19   ROM address width
//  DATA_W       3    ROM word width (palette index)
//  ROM_LATENCY  1    cycles from registered rom_address to valid rom_q (1..3)
// PORTS
//  vga_clk      in   1               single clock; all logic on posedge
//  reset        in   1               synchronous, active-high
//  enable       in   1               0 = issue no new grants; in-flight reads still complete
//  req          in   NUM_REQ         per-requester request; held until granted
//  req_addr     in   NUM_REQ*ADDR_W  flattened; slice i = requester i address, held with req[i]
//  grant        out  NUM_REQ         one-hot (or 0) accept, combinational, same cycle as req
//  rom_address  out  ADDR_W          registered address to the ROM
//  rom_q        in   DATA_W          ROM read data
//  rsp_valid    out  1               rsp_id and rsp_data valid this cycle
//  rsp_id       out  $clog2(NUM_REQ) requester that owns rsp_data
//  rsp_data     out  DATA_W          rom_q, forwarded
//  busy         out  1               any read in flight
// BEHAVIOUR
//  - Reset: rr_ptr=0, rom_address=0, pipeline valid bits=0, rsp_valid=0, rsp_id=0, busy=0.
//    grant=0 while reset is high. Reset mid-read drops all in-flight reads; no rsp is issued.
//  - Arbitration: when enable=1 and req!=0, grant the first set req bit searching from
//    rr_ptr upward with wrap (NUM_REQ-1 -> 0). Exactly one grant per cycle.
//  - On a grant to k: at the next edge rom_address<=req_addr[k] and rr_ptr<=(k+1)%NUM_REQ.
//    With no grant, rom_address and rr_ptr hold.
//  - Requester contract: req[i] and its address are stable until grant[i]=1. Requester may
//    deassert on the grant cycle or re-request next cycle.
//  - Latency: grant in cycle t -> rsp_valid=1 in cycle t+1+ROM_LATENCY, rsp_id=k,
//    rsp_data=rom_q. Issue pipe {valid,id} has depth 1+ROM_LATENCY; at most one rsp/cycle.
//    Throughput: 1 read/cycle, back-to-back.
//  - enable 1->0: grant=0 from that cycle on. Queued reads drain. busy=OR of pipe valid bits.
//  - Simultaneous: req bit dropped in the same cycle rr_ptr points at it -> next set bit wins.
//    All req set continuously -> strict rotation 0,1,2,3,0...
//  - Fairness: requester i with req held waits at most NUM_REQ-1 cycles while enable=1.
//  - Widths: rr_ptr and rsp_id are $clog2(NUM_REQ) bits. Wrap uses explicit compare, not
//    power-of-two overflow, so NUM_REQ need not be a power of two.
// STRUCTURE
//  - sprite_rom_pkg: SPR_ADDR_W, SPR_DATA_W, req_id_t, typedef for the issue-pipe entry
//    struct {logic valid; req_id_t id;}.
//  - Sub-module rr_pick (combinational): inputs req and rr_ptr; outputs one-hot grant and
//    encoded winner ID. Rotate-mask, priority-encode, un-rotate.
//  - Top: rr_ptr register, rom_address register, issue-pipe shift register, response outputs.
// TESTING
//  1. Reset: hold reset 3 cycles with req=4'b1111 -> grant=0, rsp_valid=0, busy=0,
//     rom_address=0.
//  2. Single: req=4'b0100, addr[2]=19'h1F40 -> grant=4'b0100 same cycle;
//     rom_address=19'h1F40 next cycle; rsp_valid with rsp_id=2 at t+2 (ROM_LATENCY=1).
//  3. Rotation: all req held 8 cycles -> grant sequence 1,2,4,8,1,2,4,8; rsp_id 0,1,2,3,...
//     Responses are back-to-back with data matching the ROM model.
//  4. Wrap/skip: rr_ptr=3, req=4'b0011 -> grant req0, then req1. rr_ptr ends at 2.
//  5. Enable drop: grant to 1 and 2 in consecutive cycles, then enable=0 -> no further grants.
//     Both rsps arrive. busy falls after the last rsp.
//  6. Reset mid-flight: grant in cycle t, reset in t+1 -> no rsp_valid at t+2. rr_ptr=0.
//     Repeat with ROM_LATENCY=3 to confirm latency t+4.

Source files
------------

// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and defaults for the sprite ROM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package sprite_rom_arbiter_pkg;

  localparam int SPR_NUM_REQ     = 4;
  localparam int SPR_ADDR_W      = 19;
  localparam int SPR_DATA_W      = 3;
  localparam int SPR_ROM_LATENCY = 1;

  // The ID type is sized for the largest supported requester count (8), so
  // one pipe-entry type serves every legal NUM_REQ.
  localparam int SPR_MAX_REQ = 8;
  localparam int SPR_ID_W    = $clog2(SPR_MAX_REQ);

  typedef logic [SPR_ID_W-1:0] req_id_t;

  // One slot of the issue pipe: a read in flight and who asked for it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } pipe_ent_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bundle between the sprite renderers / ROM and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests wait on grant; responses cannot be stalled.
// Signals: enable, req, req_addr (flattened), grant, rom_address, rom_q,
//          rsp_valid, rsp_id, rsp_data, busy.
interface sprite_rom_arbiter_if
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SPR_NUM_REQ,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int DATA_W  = SPR_DATA_W
) ();

  localparam int ID_W = $clog2(NUM_REQ);

  logic                      enable;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  // Requesters plus the ROM: they drive requests and ROM data.
  modport master (
    output enable, req, req_addr, rom_q,
    input  grant, rom_address, rsp_valid, rsp_id, rsp_data, busy
  );

  // The arbiter itself.
  modport slave (
    input  enable, req, req_addr, rom_q,
    output grant, rom_address, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; a zero req vector gives a zero grant.
// Ports: req_i, rr_ptr_i in; grant_o (one-hot or 0), winner_o (encoded) out.
module sprite_rom_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    winner_o
);

  // Modular add by explicit compare so non-power-of-two counts wrap correctly.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  logic [NUM_REQ-1:0] rot;
  logic               any_req;
  logic [ID_W-1:0]    off;

  always_comb begin
    rot      = '0;
    any_req  = 1'b0;
    off      = '0;
    grant_o  = '0;
    // Rotate so the pointer position lands at bit 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[wrap_add(rr_ptr_i, i)];
    end
    // Lowest set bit of the rotated vector is the winner's offset.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        off     = i[ID_W-1:0];
      end
    end
    // Undo the rotation.
    winner_o = wrap_add(rr_ptr_i, int'(off));
    if (any_req) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port among NUM_REQ requesters, tagging data by owner.
// Latency: grant in cycle t -> rsp_valid in cycle t+1+ROM_LATENCY; 1 read/cycle.
// Backpressure: req held until grant; responses are never stalled.
// Ports: vga_clk, reset (sync, active-high); arb (slave modport) carries requests,
//        grant, ROM address/data and tagged responses.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = SPR_NUM_REQ,
  parameter int ADDR_W      = SPR_ADDR_W,
  parameter int DATA_W      = SPR_DATA_W,
  parameter int ROM_LATENCY = SPR_ROM_LATENCY
) (
  input logic                 vga_clk,
  input logic                 reset,
  sprite_rom_arbiter_if.slave arb
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + ROM_LATENCY;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  pipe_ent_t          pipe_q [DEPTH];
  pipe_ent_t          pipe_d [DEPTH];

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    winner;
  logic               grant_vld;

  sprite_rom_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i    (arb.req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .winner_o (winner)
  );

  // No grants while disabled or held in reset; in-flight reads keep shifting.
  assign arb.grant = (arb.enable && !reset) ? pick_grant : '0;
  assign grant_vld = |arb.grant;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    pipe_d[0]  = '0;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    if (grant_vld) begin
      rom_addr_d      = arb.req_addr[int'(winner)*ADDR_W +: ADDR_W];
      rr_ptr_d        = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
      pipe_d[0].valid = 1'b1;
      pipe_d[0].id    = req_id_t'(winner);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rom_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // The last pipe slot lines up with the ROM word for that read.
  pipe_ent_t tail;
  assign tail = pipe_q[DEPTH-1];

  assign arb.rom_address = rom_addr_q;
  assign arb.rsp_valid   = tail.valid;
  assign arb.rsp_id      = tail.id[ID_W-1:0];
  assign arb.rsp_data    = arb.rom_q;

  logic unused_id_bits;
  assign unused_id_bits = ^tail.id;

  always_comb begin
    arb.busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) arb.busy = arb.busy | pipe_q[i].valid;
  end

endmodule
